// File: rtl/riscv_multi_top.sv
// Multi-cycle RV32I core with an FSM controller and one unified I/D memory.
// Supports lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   rst     in   synchronous active-low reset
//   pc      out  current PC register
//   instr   out  instruction register
//   alu_out out  ALU result register
//   state   out  FSM state encoding (debug)
//   retire  out  pulse in the final cycle of each completed instruction
//   halt    out  sticky flag set when an unsupported opcode is decoded
//
// Submodules riscv_multi_rf and riscv_multi_mem live in this file; their storage
// arrays (_reg, _mem) are not reset so benches can preload them.

module riscv_multi_rf (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] _reg [32];

    always_ff @(posedge clk) begin
        if (we_i && (wa_i != 5'd0)) begin
            _reg[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : _reg[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : _reg[ra2_i];
endmodule

module riscv_multi_mem #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   _mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          unused_ok;

    // Word address; high bits wrap and byte offset is ignored.
    assign idx       = addr_i[AW+1:2];
    assign unused_ok = ^{addr_i[31:AW+2], addr_i[1:0]};
    assign rd_o      = _mem[idx];

    always_ff @(posedge clk) begin
        if (we_i) begin
            _mem[idx] <= wd_i;
        end
    end
endmodule

module riscv_multi_top #(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] alu_out,
    output logic [3:0]  state,
    output logic        retire,
    output logic        halt
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT
    } alu_op_t;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] oldpc_q, oldpc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] data_q, data_d;
    logic        halt_q, halt_d;

    logic [31:0] rd1, rd2, mem_rdata, mem_addr;
    logic        rf_we, mem_we, retire_c;
    logic [31:0] rf_wd;
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_t     alu_op, fn_op;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                     ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                     ir_q[20], ir_q[30:21], 1'b0};

    // Writes are gated by rst so a reset mid-instruction aborts cleanly.
    riscv_multi_rf rf (
        .clk   (clk),
        .we_i  (rf_we & rst),
        .ra1_i (ir_q[19:15]),
        .ra2_i (ir_q[24:20]),
        .wa_i  (ir_q[11:7]),
        .wd_i  (rf_wd),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    riscv_multi_mem #(.MEM_WORDS(MEM_WORDS)) mem (
        .clk    (clk),
        .we_i   (mem_we & rst),
        .addr_i (mem_addr),
        .wd_i   (b_q),
        .rd_o   (mem_rdata)
    );

    // funct3 decode shared by R and I forms; sub only exists in R form.
    always_comb begin
        fn_op = OP_ADD;
        unique case (funct3)
            3'b000:  fn_op = (opcode == OPC_R && ir_q[30]) ? OP_SUB : OP_ADD;
            3'b010:  fn_op = OP_SLT;
            3'b110:  fn_op = OP_OR;
            3'b111:  fn_op = OP_AND;
            default: fn_op = OP_ADD;
        endcase
    end

    always_comb begin
        alu_y = 32'd0;
        unique case (alu_op)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        data_d   = data_q;
        halt_d   = halt_q;
        rf_we    = 1'b0;
        rf_wd    = alu_q;
        mem_we   = 1'b0;
        mem_addr = alu_q;
        retire_c = 1'b0;
        alu_a    = a_q;
        alu_b    = b_q;
        alu_op   = OP_ADD;

        unique case (state_q)
            S_FETCH: begin
                mem_addr = pc_q;
                ir_d     = mem_rdata;
                oldpc_d  = pc_q;
                alu_a    = pc_q;
                alu_b    = 32'd4;
                pc_d     = alu_y;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                a_d   = rd1;
                b_d   = rd2;
                alu_a = oldpc_q;
                alu_b = imm_b;
                alu_d = alu_y;
                unique case (opcode)
                    OPC_LW, OPC_SW: state_d = S_MEMADR;
                    OPC_R:          state_d = S_EXECR;
                    OPC_I:          state_d = S_EXECI;
                    OPC_BEQ:        state_d = S_BEQ;
                    OPC_JAL:        state_d = S_JAL;
                    default: begin
                        state_d = S_HALT;
                        halt_d  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_b   = (opcode == OPC_SW) ? imm_s : imm_i;
                alu_d   = alu_y;
                state_d = (opcode == OPC_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                data_d  = mem_rdata;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wd    = data_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_we   = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                alu_op  = fn_op;
                alu_d   = alu_y;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alu_b   = imm_i;
                alu_op  = fn_op;
                alu_d   = alu_y;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                if (a_q == b_q) begin
                    pc_d = alu_q;
                end
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // pc already holds oldpc+4, the link value.
                rf_we    = 1'b1;
                rf_wd    = pc_q;
                alu_a    = oldpc_q;
                alu_b    = imm_j;
                pc_d     = alu_y;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            oldpc_q <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            data_q  <= 32'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            oldpc_q <= oldpc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
            halt_q  <= halt_d;
        end
    end

    assign pc      = pc_q;
    assign instr   = ir_q;
    assign alu_out = alu_q;
    assign state   = state_q;
    assign retire  = retire_c & rst;
    assign halt    = halt_q;
endmodule

// File: tb/tb_riscv_multi_top.sv
// Bench for riscv_multi_top: scoreboard of expected retire cycles and PCs,
// plus register/memory end-state checks per program.

module tb_riscv_multi_top;
    logic        clk;
    logic        rst;
    logic [31:0] pc, instr, alu_out;
    logic [3:0]  state;
    logic        retire, halt;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } ret_t;

    ret_t sb[$];

    riscv_multi_top #(.MEM_WORDS(64), .RESET_PC(32'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .pc      (pc),
        .instr   (instr),
        .alu_out (alu_out),
        .state   (state),
        .retire  (retire),
        .halt    (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        dut.mem._mem[0]  = 32'hffc4a303;
        dut.mem._mem[1]  = 32'h0064a423;
        dut.mem._mem[2]  = 32'h0062e233;
        dut.mem._mem[3]  = 32'hfe420ae3;
        dut.mem._mem[16] = 32'hdeadc0de;
        dut.mem._mem[19] = 32'h0;
        dut.rf._reg[9]   = 32'h44;
        dut.rf._reg[5]   = 32'hfffffffe;
        dut.rf._reg[6]   = 32'h0;
        dut.rf._reg[4]   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", pc);
        else passes++;
        checks++;
        if (state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state);
        else passes++;
        checks++;
        if (retire !== 1'b0) $display("FAIL reset_retire got=%b exp=0", retire);
        else passes++;
        checks++;
        if (halt !== 1'b0) $display("FAIL reset_halt got=%b exp=0", halt);
        else passes++;
        checks++;
        if (instr !== 32'h0 || alu_out !== 32'h0)
            $display("FAIL reset_ir_alu got=%h/%h exp=0/0", instr, alu_out);
        else passes++;
        checks++;
        if (dut.rf._reg[9] !== 32'h44)
            $display("FAIL reset_rf_kept got=%h exp=44", dut.rf._reg[9]);
        else passes++;
    endtask

    task automatic test_loop();
        ret_t e;
        bit   hit;
        sb.delete();
        sb.push_back('{5,  32'h4});
        sb.push_back('{9,  32'h8});
        sb.push_back('{13, 32'hc});
        sb.push_back('{16, 32'h0});
        sb.push_back('{21, 32'h4});
        rst = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            hit = 1'b0;
            if (retire === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL loop_extra_retire cycle=%0d exp=none", c);
                end else begin
                    e   = sb.pop_front();
                    hit = 1'b1;
                    if (c !== e.cyc)
                        $display("FAIL loop_retire_cycle got=%0d exp=%0d", c, e.cyc);
                    else passes++;
                end
            end
            @(posedge clk);
            #1;
            if (hit) begin
                checks++;
                if (pc !== e.pc)
                    $display("FAIL loop_retire_pc got=%h exp=%h", pc, e.pc);
                else passes++;
            end
        end
        checks++;
        if (sb.size() != 0)
            $display("FAIL loop_missing_retires got=%0d exp=0", sb.size());
        else passes++;
        checks++;
        if (dut.rf._reg[6] !== 32'hdeadc0de)
            $display("FAIL lw_x6 got=%h exp=deadc0de", dut.rf._reg[6]);
        else passes++;
        checks++;
        if (dut.mem._mem[19] !== 32'hdeadc0de)
            $display("FAIL sw_mem19 got=%h exp=deadc0de", dut.mem._mem[19]);
        else passes++;
        checks++;
        if (dut.rf._reg[4] !== 32'hfffffffe)
            $display("FAIL or_x4 got=%h exp=fffffffe", dut.rf._reg[4]);
        else passes++;
    endtask

    task automatic test_itype_jal();
        ret_t e;
        bit   hit;
        do_reset();
        dut.mem._mem[0] = 32'hfff00093;
        dut.mem._mem[1] = 32'h0000a113;
        dut.mem._mem[2] = 32'h008001ef;
        dut.mem._mem[3] = 32'h00500013;
        dut.mem._mem[4] = 32'h00500013;
        dut.mem._mem[5] = 32'h00000433;
        dut.mem._mem[6] = 32'h00000000;
        dut.rf._reg[1]  = 32'haaaaaaaa;
        dut.rf._reg[2]  = 32'haaaaaaaa;
        dut.rf._reg[3]  = 32'haaaaaaaa;
        dut.rf._reg[8]  = 32'h55;
        sb.delete();
        sb.push_back('{4,  32'h4});
        sb.push_back('{8,  32'h8});
        sb.push_back('{11, 32'h10});
        sb.push_back('{15, 32'h14});
        sb.push_back('{19, 32'h18});
        rst = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            hit = 1'b0;
            if (retire === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL ij_extra_retire cycle=%0d exp=none", c);
                end else begin
                    e   = sb.pop_front();
                    hit = 1'b1;
                    if (c !== e.cyc)
                        $display("FAIL ij_retire_cycle got=%0d exp=%0d", c, e.cyc);
                    else passes++;
                end
            end
            @(posedge clk);
            #1;
            if (hit) begin
                checks++;
                if (pc !== e.pc)
                    $display("FAIL ij_retire_pc got=%h exp=%h", pc, e.pc);
                else passes++;
            end
        end
        checks++;
        if (sb.size() != 0)
            $display("FAIL ij_missing_retires got=%0d exp=0", sb.size());
        else passes++;
        checks++;
        if (dut.rf._reg[1] !== 32'hffffffff)
            $display("FAIL addi_x1 got=%h exp=ffffffff", dut.rf._reg[1]);
        else passes++;
        checks++;
        if (dut.rf._reg[2] !== 32'h1)
            $display("FAIL slti_x2 got=%h exp=1", dut.rf._reg[2]);
        else passes++;
        checks++;
        if (dut.rf._reg[3] !== 32'hc)
            $display("FAIL jal_x3 got=%h exp=c", dut.rf._reg[3]);
        else passes++;
        checks++;
        if (dut.rf._reg[8] !== 32'h0)
            $display("FAIL x0_reads_zero got=%h exp=0", dut.rf._reg[8]);
        else passes++;
    endtask

    task automatic test_illegal();
        int nret;
        do_reset();
        dut.mem._mem[0] = 32'h0;
        rst  = 1'b1;
        nret = 0;
        for (int c = 1; c <= 14; c++) begin
            if (retire === 1'b1) nret++;
            if (c == 2) begin
                checks++;
                if (halt !== 1'b0)
                    $display("FAIL halt_early got=%b exp=0", halt);
                else passes++;
            end
            @(posedge clk);
            #1;
            if (c == 2) begin
                checks++;
                if (halt !== 1'b1 || state !== 4'd11)
                    $display("FAIL halt_set got=%b/%0d exp=1/11", halt, state);
                else passes++;
            end
        end
        checks++;
        if (nret != 0) $display("FAIL halt_retire got=%0d exp=0", nret);
        else passes++;
        checks++;
        if (pc !== 32'h4) $display("FAIL halt_pc got=%h exp=4", pc);
        else passes++;
        checks++;
        if (halt !== 1'b1) $display("FAIL halt_sticky got=%b exp=1", halt);
        else passes++;
    endtask

    task automatic test_midop_reset();
        do_reset();
        checks++;
        if (halt !== 1'b0) $display("FAIL halt_clear got=%b exp=0", halt);
        else passes++;
        dut.mem._mem[0]  = 32'hffc4a303;
        dut.mem._mem[16] = 32'hdeadc0de;
        dut.rf._reg[9]   = 32'h44;
        dut.rf._reg[6]   = 32'h1234;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd3) $display("FAIL midop_memread got=%0d exp=3", state);
        else passes++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h0 || state !== 4'd0 || retire !== 1'b0)
            $display("FAIL midop_reset got=%h/%0d/%b exp=0/0/0",
                     pc, state, retire);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut.rf._reg[6] !== 32'h1234)
            $display("FAIL midop_no_wb got=%h exp=1234", dut.rf._reg[6]);
        else passes++;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_loop();
        test_itype_jal();
        test_illegal();
        test_midop_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
